// File: rtl/trap_pkg.sv
// Shared definitions for the M-mode trap sequencer: FSM states, cause codes and
// the priority-encoder result record.
package trap_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRAIN    = 3'd1;
  localparam logic [2:0] ST_TRAP     = 3'd2;
  localparam logic [2:0] ST_MRET     = 3'd3;
  localparam logic [2:0] ST_REDIRECT = 3'd4;

  localparam logic [4:0] CAUSE_INST_ADDR  = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_LD_ADDR    = 5'd4;
  localparam logic [4:0] CAUSE_ST_ADDR    = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam logic [31:0] INT_BIT = 32'h8000_0000;

  localparam logic [1:0] TVAL_ZERO    = 2'd0;
  localparam logic [1:0] TVAL_BADADDR = 2'd1;
  localparam logic [1:0] TVAL_INST    = 2'd2;

  typedef struct packed {
    logic       take;
    logic       is_irq;
    logic       is_mret;
    logic [4:0] code;
    logic [1:0] tval_sel;
  } prio_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Commit-point event arbiter: exceptions beat MRET, MRET beats interrupts.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic       i_ex_inst_addr,
  input  logic       i_ex_illegal,
  input  logic       i_ebreak,
  input  logic       i_ecall,
  input  logic       i_ex_ld_addr,
  input  logic       i_ex_st_addr,
  input  logic       i_mret,
  input  logic [2:0] i_irq_pend,  // {MEI, MTI, MSI}, already enable-masked
  output prio_t      o_prio
);

  always_comb begin
    o_prio = '0;
    if (i_ex_inst_addr) begin
      o_prio.take     = 1'b1;
      o_prio.code     = CAUSE_INST_ADDR;
      o_prio.tval_sel = TVAL_BADADDR;
    end else if (i_ex_illegal) begin
      o_prio.take     = 1'b1;
      o_prio.code     = CAUSE_ILLEGAL;
      o_prio.tval_sel = TVAL_INST;
    end else if (i_ebreak) begin
      o_prio.take = 1'b1;
      o_prio.code = CAUSE_BREAKPOINT;
    end else if (i_ecall) begin
      o_prio.take = 1'b1;
      o_prio.code = CAUSE_ECALL_M;
    end else if (i_ex_ld_addr) begin
      o_prio.take     = 1'b1;
      o_prio.code     = CAUSE_LD_ADDR;
      o_prio.tval_sel = TVAL_BADADDR;
    end else if (i_ex_st_addr) begin
      o_prio.take     = 1'b1;
      o_prio.code     = CAUSE_ST_ADDR;
      o_prio.tval_sel = TVAL_BADADDR;
    end else if (i_mret) begin
      o_prio.take    = 1'b1;
      o_prio.is_mret = 1'b1;
    end else if (i_irq_pend[2]) begin
      o_prio.take   = 1'b1;
      o_prio.is_irq = 1'b1;
      o_prio.code   = IRQ_MEI;
    end else if (i_irq_pend[0]) begin
      o_prio.take   = 1'b1;
      o_prio.is_irq = 1'b1;
      o_prio.code   = IRQ_MSI;
    end else if (i_irq_pend[1]) begin
      o_prio.take   = 1'b1;
      o_prio.is_irq = 1'b1;
      o_prio.code   = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the commit-point event, drains the pipe,
// strobes the CSR update and hands the new fetch target over a valid/ready port.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          VECTORED = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic            i_ex_illegal,
  input  logic            i_ex_inst_addr,
  input  logic            i_ex_ld_addr,
  input  logic            i_ex_st_addr,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_mret,
  input  logic            i_irq_msi,
  input  logic            i_irq_mti,
  input  logic            i_irq_mei,
  input  logic            i_mstatus_mie,
  input  logic [2:0]      i_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_mem_busy,
  input  logic            i_redirect_ready,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_trap_we,
  output logic            o_mret_we,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_epc,
  output logic [XLEN-1:0] o_tval,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_target;

  logic [2:0]      w_irq_pend;
  prio_t           w_prio;
  logic            w_take;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic [XLEN-1:0] w_vec_off;

  assign w_irq_pend = {i_irq_mei, i_irq_mti, i_irq_msi} & i_mie & {3{i_mstatus_mie}};

  trap_prio_enc u_prio_enc (
    .i_ex_inst_addr (i_ex_inst_addr),
    .i_ex_illegal   (i_ex_illegal),
    .i_ebreak       (i_ebreak),
    .i_ecall        (i_ecall),
    .i_ex_ld_addr   (i_ex_ld_addr),
    .i_ex_st_addr   (i_ex_st_addr),
    .i_mret         (i_mret),
    .i_irq_pend     (w_irq_pend),
    .o_prio         (w_prio)
  );

  assign w_take    = (r_state == ST_IDLE) && i_valid && w_prio.take;
  assign w_cause   = {w_prio.is_irq, {(XLEN-6){1'b0}}, w_prio.code};
  assign w_vec_off = XLEN'({r_cause[4:0], 2'b00});

  always_comb begin
    w_tval = '0;
    case (w_prio.tval_sel)
      TVAL_BADADDR: w_tval = i_badaddr;
      TVAL_INST:    w_tval = XLEN'(i_inst);
      default:      w_tval = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= ST_IDLE;
      r_cause  <= '0;
      r_epc    <= '0;
      r_tval   <= '0;
      r_target <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            if (w_prio.is_mret) begin
              r_target <= i_mepc;
              r_state  <= ST_MRET;
            end else begin
              r_cause <= w_cause;
              r_epc   <= i_pc;
              r_tval  <= w_tval;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!i_mem_busy) r_state <= ST_TRAP;
        end
        ST_TRAP: begin
          // mtvec is sampled here so a CSR write landing during the drain is honoured
          r_target <= (VECTORED && r_cause[XLEN-1]) ? i_mtvec + w_vec_off : i_mtvec;
          r_state  <= ST_REDIRECT;
        end
        ST_MRET: r_state <= ST_REDIRECT;
        ST_REDIRECT: begin
          if (i_redirect_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall          = (r_state != ST_IDLE);
  assign o_flush          = w_take && i_rst;
  assign o_trap_we        = (r_state == ST_TRAP);
  assign o_mret_we        = (r_state == ST_MRET);
  assign o_redirect_valid = (r_state == ST_REDIRECT);
  assign o_redirect_pc    = r_target;
  assign o_cause          = r_cause;
  assign o_epc            = r_epc;
  assign o_tval           = r_tval;

endmodule
